sdrc_app_monitor: RTL and testbench
===================================

SDRC_APP_MONITOR -- requirements
Module: sdrc_app_monitor

Interface
REQ-001 Parameters SHALL be (name, default, meaning): APP_AW, 26, request address width; BL_W, 9, burst length width; DEPTH, 4, outstanding requests tracked per direction (power of 2); TIMEOUT, 1024, maximum unacknowledged request cycles; CNT_W, 16, statistics counter width.
REQ-002 Ports SHALL be (name direction width meaning): sdram_clk in 1 monitor clock; sdram_resetn in 1 asynchronous active-low reset.
REQ-003 app_req in 1, app_req_addr in APP_AW, app_req_len in BL_W (beats), app_req_wr_n in 1 (0 = write), app_req_ack in 1: observed request handshake.
REQ-004 app_wr_next_req in 1 (write beat taken), app_last_wr in 1, app_rd_valid in 1 (read beat), app_last_rd in 1: observed data phase.
REQ-005 sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n in 1 each: observed SDRAM command pins.
REQ-006 clr in 1: synchronous clear of counters and error flags.
REQ-007 err_flags out 8: sticky errors; err_pulse out 1: any new error this cycle.
REQ-008 wr_outstanding and rd_outstanding out $clog2(DEPTH)+1: tracked request counts.
REQ-009 cnt_wr_bursts, cnt_rd_bursts, cnt_refresh out CNT_W: statistics counters.

Function
REQ-010 The block SHALL be passive, with no outputs driven toward the DUT.
REQ-011 Acceptance SHALL be app_req && app_req_ack on a rising sdram_clk edge; app_req_len is pushed into the write FIFO (wr_n=0) or read FIFO (wr_n=1).
REQ-012 app_req_len==0 on acceptance SHALL set err_flags[0] (ZERO_LEN) and SHALL NOT push.
REQ-013 Any change of addr/len/wr_n while app_req=1 and ack=0 versus the previous cycle SHALL set err_flags[1] (UNSTABLE).
REQ-014 A wait counter SHALL count cycles of app_req=1 && ack=0; reaching TIMEOUT SHALL set err_flags[2] once per request; the counter SHALL clear on ack or app_req=0.
REQ-015 Push to a full FIFO SHALL set err_flags[3] (OVF) and drop the request; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-016 Each direction SHALL keep a beat counter against the FIFO head length; each write beat (app_wr_next_req) or read beat (app_rd_valid) increments it.
REQ-017 A beat with an empty FIFO SHALL set err_flags[4] (WR_ORPHAN) or err_flags[5] (RD_ORPHAN) and leave counters unchanged.
REQ-018 A beat equal to the head length SHALL pop the head, reset the beat counter and increment cnt_wr_bursts or cnt_rd_bursts.
REQ-019 The last flag SHALL be required exactly on that final beat: asserted earlier sets err_flags[6] (LAST_EARLY); absent on the final beat sets err_flags[7] (LAST_MISSING).
REQ-020 A request accepted in the same cycle as a beat SHALL NOT receive that beat unless the FIFO was non-empty before the cycle.
REQ-021 cs_n=0, ras_n=0, cas_n=0, we_n=1 (auto refresh) SHALL increment cnt_refresh.
REQ-022 All counters SHALL saturate at all-ones.
REQ-023 err_pulse SHALL be 1 for exactly the cycle in which any error condition is detected, whether or not the flag was already set.
REQ-024 clr SHALL zero counters and err_flags but SHALL NOT flush the FIFOs; on a simultaneous event, clr SHALL win for counters and flags.

Reset
REQ-025 sdram_resetn low SHALL asynchronously clear the FIFOs, beat counters, wait counter, statistics counters, err_flags and err_pulse to 0; outstanding outputs SHALL read 0.
REQ-026 Reset asserted mid-burst SHALL discard tracking with no error raised; monitoring SHALL resume on the first edge after deassertion.

Structure
REQ-027 A shared package sdrc_mon_pkg SHALL hold the error-bit index constants (ERR_ZERO_LEN..ERR_LAST_MISSING) and the SDRAM command encoding constants.
REQ-028 One sub-module sdrc_mon_fifo (parametrised DEPTH x BL_W, push/pop/full/empty/count) SHALL be instantiated twice, once for writes and once for reads.

Verification
REQ-029 Write len=4 acked, 4 app_wr_next_req beats with app_last_wr on beat 4 -> cnt_wr_bursts=1, err_flags=0, wr_outstanding returns to 0.
REQ-030 Read len=8 with app_last_rd on beat 5 -> err_flags[6]=1 and err_pulse high one cycle; the burst still completes on beat 8 and err_flags[7]=1.
REQ-031 Five read requests with DEPTH=4 and no read beats -> fifth sets err_flags[3]; rd_outstanding=4.
REQ-032 app_req held 1024 cycles without ack -> err_flags[2] set at cycle 1024 and once only; addr changed mid-wait -> err_flags[1].
REQ-033 app_rd_valid with no outstanding read -> err_flags[5]; three refresh commands -> cnt_refresh=3; clr -> all zero.
REQ-034 Reset asserted during beat 2 of a len=4 write -> outputs 0 immediately; a new len=2 write after reset completes with err_flags=0.

Source files
------------

// File: rtl/sdrc_mon_pkg.sv
// Shared constants for the SDRAM controller application-interface monitor:
// error-bit indices, direction indices and SDRAM command encodings.
package sdrc_mon_pkg;

    localparam int NUM_ERR          = 8;
    localparam int ERR_ZERO_LEN     = 0;
    localparam int ERR_UNSTABLE     = 1;
    localparam int ERR_TIMEOUT      = 2;
    localparam int ERR_OVF          = 3;
    localparam int ERR_WR_ORPHAN    = 4;
    localparam int ERR_RD_ORPHAN    = 5;
    localparam int ERR_LAST_EARLY   = 6;
    localparam int ERR_LAST_MISSING = 7;

    localparam int DIR_WR = 0;
    localparam int DIR_RD = 1;

    // Command encoding as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    function automatic logic is_refresh(input logic [3:0] cmd);
        return cmd == CMD_REFRESH;
    endfunction

endpackage

// File: rtl/sdrc_mon_fifo.sv
// Small first-word-fall-through FIFO of burst lengths; head is read
// combinationally so the beat tracker can compare against it every cycle.
module sdrc_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign empty   = count_reg == '0;
    assign full    = count_reg == FULL_CNT;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sdrc_app_monitor.sv
// Passive protocol monitor for the SDRAM controller application interface:
// tracks outstanding bursts per direction, flags protocol errors, counts events.
module sdrc_app_monitor
    import sdrc_mon_pkg::*;
#(
    parameter int APP_AW  = 26,
    parameter int BL_W    = 9,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_resetn,
    input  logic                     app_req,
    input  logic [APP_AW-1:0]        app_req_addr,
    input  logic [BL_W-1:0]          app_req_len,
    input  logic                     app_req_wr_n,
    input  logic                     app_req_ack,
    input  logic                     app_wr_next_req,
    input  logic                     app_last_wr,
    input  logic                     app_rd_valid,
    input  logic                     app_last_rd,
    input  logic                     sdr_cs_n,
    input  logic                     sdr_ras_n,
    input  logic                     sdr_cas_n,
    input  logic                     sdr_we_n,
    input  logic                     clr,
    output logic [NUM_ERR-1:0]       err_flags,
    output logic                     err_pulse,
    output logic [$clog2(DEPTH):0]   wr_outstanding,
    output logic [$clog2(DEPTH):0]   rd_outstanding,
    output logic [CNT_W-1:0]         cnt_wr_bursts,
    output logic [CNT_W-1:0]         cnt_rd_bursts,
    output logic [CNT_W-1:0]         cnt_refresh
);
    localparam int OW     = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic              accept;
    logic              waiting;
    logic              len_zero;
    logic [1:0]        push_req;
    logic [1:0]        beat;
    logic [1:0]        last;
    logic [1:0]        orphan;
    logic [1:0]        last_early;
    logic [1:0]        last_missing;
    logic [1:0]        overflow;
    logic [1:0]        burst_done;
    logic [1:0][OW-1:0] fifo_count;

    logic [APP_AW-1:0] prev_addr_reg;
    logic [BL_W-1:0]   prev_len_reg;
    logic              prev_wr_n_reg;
    logic              prev_wait_reg;
    logic              unstable;

    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              timeout_hit;

    logic [NUM_ERR-1:0] new_err;
    logic [NUM_ERR-1:0] err_flags_reg;
    logic               err_pulse_reg;
    logic [2:0]         cnt_inc;

    assign accept   = app_req && app_req_ack;
    assign waiting  = app_req && !app_req_ack;
    assign len_zero = app_req_len == '0;
    assign push_req[DIR_WR] = accept && !len_zero && !app_req_wr_n;
    assign push_req[DIR_RD] = accept && !len_zero &&  app_req_wr_n;
    assign beat = {app_rd_valid, app_wr_next_req};
    assign last = {app_last_rd, app_last_wr};

    // Per-direction length FIFO plus beat tracker against the head burst
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
        logic [BL_W-1:0] head_len;
        logic            fifo_full;
        logic            fifo_empty;
        logic            pop_c;
        logic            orphan_c;
        logic            early_c;
        logic            missing_c;
        logic [BL_W-1:0] beat_cnt_reg;
        logic [BL_W-1:0] beat_cnt_next;
        logic [BL_W:0]   beat_inc;

        sdrc_mon_fifo #(
            .DEPTH (DEPTH),
            .W     (BL_W)
        ) u_fifo (
            .clk   (sdram_clk),
            .rst_n (sdram_resetn),
            .push  (push_req[gi]),
            .pop   (pop_c),
            .din   (app_req_len),
            .head  (head_len),
            .full  (fifo_full),
            .empty (fifo_empty),
            .count (fifo_count[gi])
        );

        assign beat_inc = {1'b0, beat_cnt_reg} + 1'b1;

        // Emptiness is the pre-cycle state, so a same-cycle push never owns this beat
        always_comb begin
            pop_c         = 1'b0;
            orphan_c      = 1'b0;
            early_c       = 1'b0;
            missing_c     = 1'b0;
            beat_cnt_next = beat_cnt_reg;
            if (beat[gi]) begin
                if (fifo_empty) begin
                    orphan_c = 1'b1;
                end else if (beat_inc == {1'b0, head_len}) begin
                    pop_c         = 1'b1;
                    beat_cnt_next = '0;
                    missing_c     = !last[gi];
                end else begin
                    beat_cnt_next = beat_inc[BL_W-1:0];
                    early_c       = last[gi];
                end
            end
        end

        always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
            if (!sdram_resetn) begin
                beat_cnt_reg <= '0;
            end else begin
                beat_cnt_reg <= beat_cnt_next;
            end
        end

        assign orphan[gi]       = orphan_c;
        assign last_early[gi]   = early_c;
        assign last_missing[gi] = missing_c;
        assign burst_done[gi]   = pop_c;
        assign overflow[gi]     = push_req[gi] && fifo_full && !pop_c;
    end

    assign wr_outstanding = fifo_count[DIR_WR];
    assign rd_outstanding = fifo_count[DIR_RD];

    // Request fields must hold while a request is waiting for its ack
    assign unstable = waiting && prev_wait_reg &&
                      ((app_req_addr != prev_addr_reg) ||
                       (app_req_len  != prev_len_reg)  ||
                       (app_req_wr_n != prev_wr_n_reg));

    assign timeout_hit = waiting && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        wait_cnt_next = '0;
        if (waiting) begin
            wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? WAIT_MAX : wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            prev_addr_reg <= '0;
            prev_len_reg  <= '0;
            prev_wr_n_reg <= 1'b0;
            prev_wait_reg <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            prev_addr_reg <= app_req_addr;
            prev_len_reg  <= app_req_len;
            prev_wr_n_reg <= app_req_wr_n;
            prev_wait_reg <= waiting;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    always_comb begin
        new_err                   = '0;
        new_err[ERR_ZERO_LEN]     = accept && len_zero;
        new_err[ERR_UNSTABLE]     = unstable;
        new_err[ERR_TIMEOUT]      = timeout_hit;
        new_err[ERR_OVF]          = |overflow;
        new_err[ERR_WR_ORPHAN]    = orphan[DIR_WR];
        new_err[ERR_RD_ORPHAN]    = orphan[DIR_RD];
        new_err[ERR_LAST_EARLY]   = |last_early;
        new_err[ERR_LAST_MISSING] = |last_missing;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            err_flags_reg <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_flags_reg <= clr ? '0 : (err_flags_reg | new_err);
            err_pulse_reg <= |new_err;
        end
    end

    assign err_flags = err_flags_reg;
    assign err_pulse = err_pulse_reg;

    // Saturating statistics: 0 = write bursts, 1 = read bursts, 2 = refresh
    assign cnt_inc = {is_refresh({sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}),
                      burst_done[DIR_RD], burst_done[DIR_WR]};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
            if (!sdram_resetn) begin
                cnt_reg <= '0;
            end else if (clr) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign cnt_wr_bursts = g_cnt[0].cnt_reg;
    assign cnt_rd_bursts = g_cnt[1].cnt_reg;
    assign cnt_refresh   = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_sdrc_app_monitor.sv
// Directed bench for sdrc_app_monitor: linear stimulus, hand-computed expectations.
module tb_sdrc_app_monitor;
    logic        sdram_clk = 1'b0;
    logic        sdram_resetn;
    logic        app_req;
    logic [25:0] app_req_addr;
    logic [8:0]  app_req_len;
    logic        app_req_wr_n;
    logic        app_req_ack;
    logic        app_wr_next_req;
    logic        app_last_wr;
    logic        app_rd_valid;
    logic        app_last_rd;
    logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic        clr;
    logic [7:0]  err_flags;
    logic        err_pulse;
    logic [2:0]  wr_outstanding;
    logic [2:0]  rd_outstanding;
    logic [15:0] cnt_wr_bursts;
    logic [15:0] cnt_rd_bursts;
    logic [15:0] cnt_refresh;

    int n_cmp = 0;
    int n_err = 0;

    sdrc_app_monitor dut (
        .sdram_clk       (sdram_clk),
        .sdram_resetn    (sdram_resetn),
        .app_req         (app_req),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_req_wr_n    (app_req_wr_n),
        .app_req_ack     (app_req_ack),
        .app_wr_next_req (app_wr_next_req),
        .app_last_wr     (app_last_wr),
        .app_rd_valid    (app_rd_valid),
        .app_last_rd     (app_last_rd),
        .sdr_cs_n        (sdr_cs_n),
        .sdr_ras_n       (sdr_ras_n),
        .sdr_cas_n       (sdr_cas_n),
        .sdr_we_n        (sdr_we_n),
        .clr             (clr),
        .err_flags       (err_flags),
        .err_pulse       (err_pulse),
        .wr_outstanding  (wr_outstanding),
        .rd_outstanding  (rd_outstanding),
        .cnt_wr_bursts   (cnt_wr_bursts),
        .cnt_rd_bursts   (cnt_rd_bursts),
        .cnt_refresh     (cnt_refresh)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        app_req = 0; app_req_addr = '0; app_req_len = '0; app_req_wr_n = 0; app_req_ack = 0;
        app_wr_next_req = 0; app_last_wr = 0; app_rd_valid = 0; app_last_rd = 0;
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = 4'b0111;
        clr = 0;
    endtask

    task automatic req(input logic wr_n, input int len, input int addr, input logic ack);
        app_req = 1; app_req_wr_n = wr_n; app_req_len = 9'(len);
        app_req_addr = 26'(addr); app_req_ack = ack;
    endtask

    task automatic wbeat(input logic lst);
        app_wr_next_req = 1; app_last_wr = lst;
    endtask

    task automatic rbeat(input logic lst);
        app_rd_valid = 1; app_last_rd = lst;
    endtask

    task automatic do_clr();
        idle(); clr = 1; tick(); clr = 0;
        $display("clear issued");
    endtask

    initial begin
        idle();
        sdram_resetn = 0;
        #12;
        chk("rst_flags", 32'(err_flags), 0);
        chk("rst_pulse", 32'(err_pulse), 0);
        chk("rst_wr_out", 32'(wr_outstanding), 0);
        chk("rst_rd_out", 32'(rd_outstanding), 0);
        chk("rst_cnt_ref", 32'(cnt_refresh), 0);
        sdram_resetn = 1;
        tick();

        // Clean write burst, len 4
        req(0, 4, 'h100, 1); tick(); idle();
        chk("wr4_out_after_req", 32'(wr_outstanding), 1);
        for (int i = 1; i <= 4; i++) begin
            wbeat(i == 4); tick(); idle();
        end
        chk("wr4_bursts", 32'(cnt_wr_bursts), 1);
        chk("wr4_flags", 32'(err_flags), 0);
        chk("wr4_out_done", 32'(wr_outstanding), 0);
        $display("write len=4 burst done");

        // Read len 8 with last on beat 5 (early) and missing on beat 8
        req(1, 8, 'h200, 1); tick(); idle();
        chk("rd8_out", 32'(rd_outstanding), 1);
        for (int i = 1; i <= 8; i++) begin
            rbeat(i == 5); tick(); idle();
            if (i == 5) begin
                chk("rd8_early_flag", 32'(err_flags), 'h40);
                chk("rd8_early_pulse", 32'(err_pulse), 1);
            end
            if (i == 6) chk("rd8_pulse_drop", 32'(err_pulse), 0);
        end
        chk("rd8_missing_flag", 32'(err_flags), 'hC0);
        chk("rd8_missing_pulse", 32'(err_pulse), 1);
        chk("rd8_bursts", 32'(cnt_rd_bursts), 1);
        chk("rd8_out_done", 32'(rd_outstanding), 0);
        $display("read len=8 burst with bad last done");

        do_clr();
        chk("clr1_flags", 32'(err_flags), 0);
        chk("clr1_wr_bursts", 32'(cnt_wr_bursts), 0);
        chk("clr1_rd_bursts", 32'(cnt_rd_bursts), 0);

        // Five reads into a depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            req(1, 2, 'h300 + i, 1); tick(); idle();
            if (i == 3) chk("ovf_pre_flags", 32'(err_flags), 0);
        end
        chk("ovf_flag", 32'(err_flags), 'h08);
        chk("ovf_pulse", 32'(err_pulse), 1);
        chk("ovf_rd_out", 32'(rd_outstanding), 4);
        $display("read overflow done");

        // Push and pop together on a full FIFO both succeed
        rbeat(0); tick(); idle();
        rbeat(1); req(1, 3, 'h400, 1); tick(); idle();
        chk("fullpp_rd_out", 32'(rd_outstanding), 4);
        chk("fullpp_pulse", 32'(err_pulse), 0);
        chk("fullpp_bursts", 32'(cnt_rd_bursts), 1);
        for (int i = 1; i <= 6; i++) begin
            rbeat(i % 2 == 0); tick(); idle();
        end
        for (int i = 1; i <= 3; i++) begin
            rbeat(i == 3); tick(); idle();
        end
        chk("drain_rd_out", 32'(rd_outstanding), 0);
        chk("drain_bursts", 32'(cnt_rd_bursts), 5);
        chk("drain_flags", 32'(err_flags), 'h08);
        $display("full push/pop and drain done");
        do_clr();

        // Zero-length request
        req(0, 0, 'h500, 1); tick(); idle();
        chk("zlen_flag", 32'(err_flags), 'h01);
        chk("zlen_wr_out", 32'(wr_outstanding), 0);
        do_clr();

        // Timeout after 1024 waiting cycles, then instability
        req(0, 4, 'h600, 0);
        repeat (1023) tick();
        chk("tmo_before", 32'(err_flags), 0);
        tick();
        chk("tmo_flag", 32'(err_flags), 'h04);
        chk("tmo_pulse", 32'(err_pulse), 1);
        tick();
        chk("tmo_pulse_drop", 32'(err_pulse), 0);
        repeat (5) tick();
        chk("tmo_once", 32'(err_pulse), 0);
        app_req_addr = 26'h601; tick();
        chk("unstable_flag", 32'(err_flags), 'h06);
        chk("unstable_pulse", 32'(err_pulse), 1);
        app_req_ack = 1; tick(); idle();
        chk("tmo_accept_out", 32'(wr_outstanding), 1);
        for (int i = 1; i <= 4; i++) begin
            wbeat(i == 4); tick(); idle();
        end
        chk("tmo_drain_out", 32'(wr_outstanding), 0);
        chk("tmo_drain_bursts", 32'(cnt_wr_bursts), 1);
        $display("timeout and unstable done");
        do_clr();

        // Orphans, refresh counting, clr against simultaneous refresh
        rbeat(1); tick(); idle();
        chk("rd_orphan", 32'(err_flags), 'h20);
        chk("rd_orphan_bursts", 32'(cnt_rd_bursts), 0);
        wbeat(1); tick(); idle();
        chk("wr_orphan", 32'(err_flags), 'h30);
        for (int i = 0; i < 3; i++) begin
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = 4'b0001; tick(); idle();
        end
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = 4'b0010; tick(); idle();
        chk("refresh_cnt", 32'(cnt_refresh), 3);
        clr = 1; {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = 4'b0001; tick(); idle();
        chk("clr_ref_wins", 32'(cnt_refresh), 0);
        chk("clr_flags", 32'(err_flags), 0);
        $display("orphans, refresh and clr done");

        // Beat in the same cycle a request lands in an empty FIFO
        req(0, 1, 'h700, 1); wbeat(1); tick(); idle();
        chk("same_cyc_orphan", 32'(err_flags), 'h10);
        chk("same_cyc_out", 32'(wr_outstanding), 1);
        wbeat(1); tick(); idle();
        chk("same_cyc_done", 32'(wr_outstanding), 0);
        chk("same_cyc_bursts", 32'(cnt_wr_bursts), 1);
        do_clr();

        // Reset during beat 2 of a len=4 write
        req(0, 4, 'h800, 1); tick(); idle();
        wbeat(0); {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = 4'b0001; tick(); idle();
        chk("pre_rst_ref", 32'(cnt_refresh), 1);
        wbeat(0);
        #2 sdram_resetn = 0;
        #1;
        chk("midrst_wr_out", 32'(wr_outstanding), 0);
        chk("midrst_ref", 32'(cnt_refresh), 0);
        chk("midrst_flags", 32'(err_flags), 0);
        idle();
        tick(); tick();
        #3 sdram_resetn = 1;
        req(0, 2, 'h900, 1); tick(); idle();
        chk("post_rst_out", 32'(wr_outstanding), 1);
        wbeat(0); tick(); idle();
        wbeat(1); tick(); idle();
        chk("post_rst_bursts", 32'(cnt_wr_bursts), 1);
        chk("post_rst_flags", 32'(err_flags), 0);
        chk("post_rst_done", 32'(wr_outstanding), 0);
        $display("reset mid-burst and recovery done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
